// File: rtl/audio_axi_pkg.sv
// Shared constants for the audio capture register slave: byte offsets, AXI responses,
// CTRL/STATUS bit positions and the FIFO level-width helper.
package audio_axi_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_DATA     = 8'h08;
    localparam logic [7:0] OFF_THRESH   = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH  = 8'h10;
    localparam logic [7:0] OFF_FRAMECNT = 8'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UNF     = 3;
    localparam int ST_LVL_LSB = 8;
    localparam int ST_CH_LSB  = 16;

    // Level must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_axi_capture_regs_if.sv
// AXI4-Lite bundle used between the interconnect (master) and the capture slave.
interface audio_axi_capture_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO; flush empties it and overrides a push or pop in the same cycle.
module audio_frame_fifo
    import audio_axi_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             flush,
    input  logic [WIDTH-1:0]                 din,
    output logic [WIDTH-1:0]                 dout,
    output logic                             full,
    output logic                             empty,
    output logic [level_width(DEPTH)-1:0]    level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/audio_axi_capture_regs.sv
// AXI4-Lite slave capturing multi-channel audio frames into a FIFO with CTRL/STATUS/DATA/THRESH/SCRATCH.
// Define AUDIO_FRAME_COUNT_EN to add the read-only pushed-frame counter at offset 0x14.
module audio_axi_capture_regs
    import audio_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int SAMPLE_WIDTH       = 24,
    parameter int NUM_CHANNELS       = 2,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic                                 frame_valid,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] frame_data,
    output logic                                 irq,
    audio_axi_capture_regs_if.slave              s_axi
);
    localparam int FW    = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int LVL_W = level_width(FIFO_DEPTH);

    logic [2:0]  ctrl_q, ctrl_d;
    logic [7:0]  thresh_q, thresh_d;
    logic [31:0] scratch_q, scratch_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic [2:0]  ch_q, ch_d;
    logic        bvalid_q, rvalid_q, irq_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
`ifdef AUDIO_FRAME_COUNT_EN
    logic [31:0] framecnt_q, framecnt_d;
`endif

    logic             rd_acc, wr_acc, push, pop, flush, data_rd;
    logic [7:0]       rd_addr, wr_addr;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [FW-1:0]    fifo_head;
    logic [31:0]      status_w, rd_data;
    logic [1:0]       rd_resp, wr_resp;
    logic             unused_prot;

    function automatic logic [31:0] sext(input logic signed [SAMPLE_WIDTH-1:0] s);
        logic signed [31:0] r;
        r = s;
        return r;
    endfunction

    // Read wins any tie; each channel holds a single transaction until its response is taken.
    assign rd_acc  = s_axi.arvalid && !rvalid_q;
    assign wr_acc  = s_axi.awvalid && s_axi.wvalid && !bvalid_q && !rd_acc;
    assign rd_addr = 8'(s_axi.araddr) & 8'hFC;
    assign wr_addr = 8'(s_axi.awaddr) & 8'hFC;

    assign s_axi.arready = rd_acc;
    assign s_axi.awready = wr_acc;
    assign s_axi.wready  = wr_acc;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign irq           = irq_q;
    assign unused_prot   = ^{s_axi.awprot, s_axi.arprot};

    assign push    = frame_valid && ctrl_q[CTRL_EN] && !fifo_full;
    assign flush   = wr_acc && (wr_addr == OFF_CTRL) && s_axi.wstrb[0] && s_axi.wdata[CTRL_FLUSH];
    assign data_rd = rd_acc && (rd_addr == OFF_DATA);
    assign pop     = data_rd && !fifo_empty && (int'(ch_q) == NUM_CHANNELS - 1);

    audio_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (S_AXI_ACLK),
        .rst  (S_AXI_ARESET),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .din  (frame_data),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    always_comb begin
        status_w                               = '0;
        status_w[ST_EMPTY]                     = fifo_empty;
        status_w[ST_FULL]                      = fifo_full;
        status_w[ST_OVF]                       = ovf_q;
        status_w[ST_UNF]                       = unf_q;
        status_w[ST_LVL_LSB +: 8]              = 8'(fifo_level);
        status_w[ST_CH_LSB +: 3]               = ch_q;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_addr)
            OFF_CTRL:     rd_data[2:0] = ctrl_q;
            OFF_STATUS:   rd_data = status_w;
            OFF_DATA:     if (!fifo_empty) rd_data = sext(fifo_head[int'(ch_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            OFF_THRESH:   rd_data[7:0] = thresh_q;
            OFF_SCRATCH:  rd_data = scratch_q;
`ifdef AUDIO_FRAME_COUNT_EN
            OFF_FRAMECNT: rd_data = framecnt_q;
`endif
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        case (wr_addr)
            OFF_CTRL, OFF_STATUS, OFF_DATA, OFF_THRESH, OFF_SCRATCH: wr_resp = RESP_OKAY;
`ifdef AUDIO_FRAME_COUNT_EN
            OFF_FRAMECNT: wr_resp = RESP_OKAY;
`endif
            default:      wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        ctrl_d             = ctrl_q;
        ctrl_d[CTRL_FLUSH] = 1'b0;
        thresh_d           = thresh_q;
        scratch_d          = scratch_q;
        ovf_d              = ovf_q;
        unf_d              = unf_q;
        ch_d               = ch_q;
        if (wr_acc) begin
            case (wr_addr)
                OFF_CTRL:    if (s_axi.wstrb[0]) ctrl_d = s_axi.wdata[2:0];
                OFF_STATUS:  if (s_axi.wstrb[0]) begin
                                 if (s_axi.wdata[ST_OVF]) ovf_d = 1'b0;
                                 if (s_axi.wdata[ST_UNF]) unf_d = 1'b0;
                             end
                OFF_THRESH:  if (s_axi.wstrb[0]) thresh_d = s_axi.wdata[7:0];
                OFF_SCRATCH: for (int b = 0; b < 4; b++)
                                 if (s_axi.wstrb[b]) scratch_d[b*8 +: 8] = s_axi.wdata[b*8 +: 8];
                default: ;
            endcase
        end
        // A set event in the same cycle as a W1C keeps the flag set.
        if (frame_valid && ctrl_q[CTRL_EN] && fifo_full) ovf_d = 1'b1;
        if (data_rd) begin
            if (fifo_empty)                             unf_d = 1'b1;
            else if (int'(ch_q) == NUM_CHANNELS - 1)    ch_d  = '0;
            else                                        ch_d  = ch_q + 1'b1;
        end
        if (flush) ch_d = '0;
    end

`ifdef AUDIO_FRAME_COUNT_EN
    always_comb begin
        framecnt_d = framecnt_q;
        if (!ctrl_q[CTRL_EN] && ctrl_d[CTRL_EN]) framecnt_d = '0;
        else if (push && !flush)                 framecnt_d = framecnt_q + 1'b1;
    end
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrl_q    <= '0;
            thresh_q  <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ch_q      <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
`ifdef AUDIO_FRAME_COUNT_EN
            framecnt_q <= '0;
`endif
        end else begin
            ctrl_q    <= ctrl_d;
            thresh_q  <= thresh_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ch_q      <= ch_d;
`ifdef AUDIO_FRAME_COUNT_EN
            framecnt_q <= framecnt_d;
`endif
            if (wr_acc) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_acc) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_resp;
                rdata_q  <= rd_data;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
            irq_q <= ctrl_q[CTRL_IRQ_EN] &&
                     (((thresh_q != 8'd0) && (int'(fifo_level) >= int'(thresh_q))) || ovf_q);
        end
    end

endmodule
